// File: rtl/noc_router_route_lookup.sv
// Per-input-port route computation: decodes the header destination through a routing table and
// holds the one-hot route for the whole packet. Optional feature macro: NOC_ROUTE_LOOKUP_DROP_EN.
module noc_router_route_lookup #(
    parameter int FLIT_WIDTH = 32,
    parameter int OUTPUTS    = 5,
    parameter int DEST_WIDTH = 5,
    parameter int DEST_MSB   = 31,
    parameter logic [OUTPUTS*(2**DEST_WIDTH)-1:0] ROUTES = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic [OUTPUTS-1:0]    out_valid,
    input  logic                  out_ready,
    output logic                  err_drop
);

`ifdef NOC_ROUTE_LOOKUP_DROP_EN
    typedef enum logic [1:0] {ST_HEAD = 2'd0, ST_BODY = 2'd1, ST_DROP = 2'd2} state_e;
`else
    typedef enum logic [0:0] {ST_HEAD = 1'b0, ST_BODY = 1'b1} state_e;
`endif

    localparam logic [OUTPUTS-1:0] ROUTE_ZERO  = {OUTPUTS{1'b0}};
    localparam logic [OUTPUTS-1:0] ROUTE_PORT0 = {{(OUTPUTS-1){1'b0}}, 1'b1};

    // Without the drop feature an empty table entry falls back to output port 0.
    function automatic logic [OUTPUTS-1:0] table_entry(input logic [DEST_WIDTH-1:0] dest);
        logic [OUTPUTS-1:0] entry;
        entry = ROUTES[int'(dest)*OUTPUTS +: OUTPUTS];
`ifdef NOC_ROUTE_LOOKUP_DROP_EN
        return entry;
`else
        return (entry == ROUTE_ZERO) ? ROUTE_PORT0 : entry;
`endif
    endfunction

    state_e                  state_q, state_d;
    logic [OUTPUTS-1:0]      route_q, route_d;
    logic [OUTPUTS-1:0]      out_valid_q, out_valid_d;
    logic [FLIT_WIDTH-1:0]   out_flit_q, out_flit_d;
    logic                    out_last_q, out_last_d;
    logic                    err_d;
    logic                    accept_s;
    logic [OUTPUTS-1:0]      route_s;

    assign route_s  = table_entry(in_flit[DEST_MSB -: DEST_WIDTH]);
`ifdef NOC_ROUTE_LOOKUP_DROP_EN
    assign in_ready = (state_q == ST_DROP) | ~(|out_valid_q) | out_ready;
`else
    assign in_ready = ~(|out_valid_q) | out_ready;
`endif
    assign accept_s = in_valid & in_ready;

    // Next-state: drain first, then a same-cycle accept reloads the output register.
    always_comb begin
        state_d     = state_q;
        route_d     = route_q;
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;
        if (out_ready & (|out_valid_q)) begin
            out_valid_d = ROUTE_ZERO;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (accept_s) begin
            case (state_q)
                ST_HEAD: begin
                    route_d = route_s;
`ifdef NOC_ROUTE_LOOKUP_DROP_EN
                    if (route_s == ROUTE_ZERO) begin
                        err_d   = 1'b1;
                        state_d = in_last ? ST_HEAD : ST_DROP;
                    end else begin
                        out_valid_d = route_s;
                        out_flit_d  = in_flit;
                        out_last_d  = in_last;
                        state_d     = in_last ? ST_HEAD : ST_BODY;
                    end
`else
                    out_valid_d = route_s;
                    out_flit_d  = in_flit;
                    out_last_d  = in_last;
                    state_d     = in_last ? ST_HEAD : ST_BODY;
`endif
                end
                ST_BODY: begin
                    out_valid_d = route_q;
                    out_flit_d  = in_flit;
                    out_last_d  = in_last;
                    state_d     = in_last ? ST_HEAD : ST_BODY;
                end
`ifdef NOC_ROUTE_LOOKUP_DROP_EN
                ST_DROP: begin
                    state_d = in_last ? ST_HEAD : ST_DROP;
                end
`endif
                default: begin
                    state_d = ST_HEAD;
                end
            endcase
        end else begin
            state_d = state_q;
            route_d = route_q;
        end
    end

    // State and output register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_HEAD;
            route_q     <= ROUTE_ZERO;
            out_valid_q <= ROUTE_ZERO;
            out_flit_q  <= {FLIT_WIDTH{1'b0}};
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            route_q     <= route_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef NOC_ROUTE_LOOKUP_DROP_EN
    logic err_q;

    // Registered drop pulse, one cycle after the dropped header is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err_drop = err_q;
`else
    assign err_drop = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_noc_router_route_lookup.sv
// Directed bench for noc_router_route_lookup with a 4-output, 4-entry table (d0:0001 d1:0010 d2:0100 d3:0000).
module tb_noc_router_route_lookup;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_flit;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_flit;
    logic        out_last;
    logic [3:0]  out_valid;
    logic        out_ready;
    logic        err_drop;

    int n_checks = 0;
    int n_fails  = 0;

`ifdef NOC_ROUTE_LOOKUP_DROP_EN
    localparam logic [3:0] EXP6_VALID = 4'b0000;
    localparam logic       EXP6_ERR   = 1'b1;
`else
    localparam logic [3:0] EXP6_VALID = 4'b0001;
    localparam logic       EXP6_ERR   = 1'b0;
`endif

    noc_router_route_lookup #(
        .FLIT_WIDTH(32),
        .OUTPUTS   (4),
        .DEST_WIDTH(2),
        .DEST_MSB  (31),
        .ROUTES    (16'h0421)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_flit  (in_flit),
        .in_last  (in_last),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_flit (out_flit),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_drop (err_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge, then advance to the next falling edge.
    task automatic drive(input logic [31:0] f, input logic l, input logic v, input logic r);
        in_flit   = f;
        in_last   = l;
        in_valid  = v;
        out_ready = r;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] v, input logic [31:0] f, input logic l);
        chk({tag, "_valid"}, {28'd0, out_valid}, {28'd0, v});
        chk({tag, "_flit"}, out_flit, f);
        chk({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cyc();
        cyc();
        chk_out("reset", 4'b0000, 32'h0, 1'b0);
        chk("reset_err", {31'd0, err_drop}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // 1: header dest1 + 2 body, last on third flit
        drive(32'h4000_0000, 1'b0, 1'b1, 1'b1); cyc();
        chk_out("t1_h", 4'b0010, 32'h4000_0000, 1'b0);
        chk("t1_rdy0", {31'd0, in_ready}, 32'd1);
        drive(32'h0000_1111, 1'b0, 1'b1, 1'b1); cyc();
        chk_out("t1_b1", 4'b0010, 32'h0000_1111, 1'b0);
        chk("t1_rdy1", {31'd0, in_ready}, 32'd1);
        drive(32'h0000_2222, 1'b1, 1'b1, 1'b1); cyc();
        chk_out("t1_b2", 4'b0010, 32'h0000_2222, 1'b1);
        drive(32'h0, 1'b0, 1'b0, 1'b1); cyc();
        chk("t1_drain", {28'd0, out_valid}, 32'd0);

        // 2: single-flit packets dest2 then dest0
        drive(32'h8000_00AA, 1'b1, 1'b1, 1'b1); cyc();
        chk_out("t2_a", 4'b0100, 32'h8000_00AA, 1'b1);
        drive(32'h0000_0000, 1'b1, 1'b1, 1'b1); cyc();
        chk_out("t2_b", 4'b0001, 32'h0000_0000, 1'b1);
        drive(32'h0, 1'b0, 1'b0, 1'b1); cyc();
        chk("t2_drain", {28'd0, out_valid}, 32'd0);

        // 3: body flits reading dest3 keep the header route across a stall
        drive(32'h4000_0000, 1'b0, 1'b1, 1'b1); cyc();
        chk_out("t3_h", 4'b0010, 32'h4000_0000, 1'b0);
        drive(32'hC000_0001, 1'b0, 1'b1, 1'b1); cyc();
        chk_out("t3_b1", 4'b0010, 32'hC000_0001, 1'b0);
        drive(32'hC000_0002, 1'b0, 1'b1, 1'b0); #1;
        chk("t3_rdy_stall1", {31'd0, in_ready}, 32'd0);
        cyc();
        chk_out("t3_hold1", 4'b0010, 32'hC000_0001, 1'b0);
        #1;
        chk("t3_rdy_stall2", {31'd0, in_ready}, 32'd0);
        cyc();
        chk_out("t3_hold2", 4'b0010, 32'hC000_0001, 1'b0);
        drive(32'hC000_0002, 1'b0, 1'b1, 1'b1); #1;
        chk("t3_rdy_go", {31'd0, in_ready}, 32'd1);
        cyc();
        chk_out("t3_b2", 4'b0010, 32'hC000_0002, 1'b0);
        drive(32'hC000_0003, 1'b1, 1'b1, 1'b1); cyc();
        chk_out("t3_b3", 4'b0010, 32'hC000_0003, 1'b1);
        drive(32'h0, 1'b0, 1'b0, 1'b1); cyc();
        chk("t3_drain", {28'd0, out_valid}, 32'd0);

        // 4: 16-flit stream, dest0, one output per cycle
        for (int i = 0; i < 16; i++) begin
            drive((i == 0) ? 32'h0000_0000 : (32'h0000_1000 + 32'(i)), (i == 15), 1'b1, 1'b1);
            cyc();
            chk("t4_valid", {28'd0, out_valid}, 32'd1);
            chk("t4_flit", out_flit, (i == 0) ? 32'h0000_0000 : (32'h0000_1000 + 32'(i)));
        end
        chk("t4_last", {31'd0, out_last}, 32'd1);
        drive(32'h0, 1'b0, 1'b0, 1'b1); cyc();
        chk("t4_drain", {28'd0, out_valid}, 32'd0);

        // 5: reset mid-packet; following flit is decoded as a header
        drive(32'h4000_0000, 1'b0, 1'b1, 1'b1); cyc();
        chk_out("t5_h", 4'b0010, 32'h4000_0000, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0; cyc();
        rst_n = 1'b1;
        chk_out("t5_rst", 4'b0000, 32'h0, 1'b0);
        drive(32'h8000_0000, 1'b1, 1'b1, 1'b1); cyc();
        chk_out("t5_hdr", 4'b0100, 32'h8000_0000, 1'b1);
        drive(32'h0, 1'b0, 1'b0, 1'b1); cyc();

        // 6: header to empty table entry (dest3)
        drive(32'hC000_0000, 1'b0, 1'b1, 1'b1); #1;
        chk("t6_rdy0", {31'd0, in_ready}, 32'd1);
        cyc();
        chk("t6_v0", {28'd0, out_valid}, {28'd0, EXP6_VALID});
        chk("t6_err0", {31'd0, err_drop}, {31'd0, EXP6_ERR});
        drive(32'h0000_0011, 1'b0, 1'b1, 1'b1); #1;
        chk("t6_rdy1", {31'd0, in_ready}, 32'd1);
        cyc();
        chk("t6_v1", {28'd0, out_valid}, {28'd0, EXP6_VALID});
        chk("t6_err1", {31'd0, err_drop}, 32'd0);
        drive(32'h0000_0022, 1'b1, 1'b1, 1'b1); #1;
        chk("t6_rdy2", {31'd0, in_ready}, 32'd1);
        cyc();
        chk("t6_v2", {28'd0, out_valid}, {28'd0, EXP6_VALID});
        chk("t6_err2", {31'd0, err_drop}, 32'd0);
        drive(32'h0, 1'b0, 1'b0, 1'b1); cyc();
        chk("t6_drain", {28'd0, out_valid}, 32'd0);
        // back in HEAD: next header routes normally
        drive(32'h4000_0000, 1'b1, 1'b1, 1'b1); cyc();
        chk_out("t6_next", 4'b0010, 32'h4000_0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
